spi_regfile: RTL and testbench
==============================

SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 SHALL have parameter RF_AWIDTH, default 4, meaning word-address width (16 words).
REQ-002 SHALL have parameter RF_WIDTH, default 32, meaning data width in bits.
REQ-003 SHALL have parameter RF_MASK, default 4, meaning byte-lane count, equal to RF_WIDTH/8.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  1  single-cycle access strobe from spi_peripheral (already synchronised to clk).
REQ-007 SHALL have port we  input  1  1 = write, 0 = read; valid when req=1.
REQ-008 SHALL have port addr  input  RF_AWIDTH  word address.
REQ-009 SHALL have port wdata  input  RF_WIDTH  write data.
REQ-010 SHALL have port wmask  input  RF_MASK  byte enables; wmask[i] gates wdata[8i+7:8i].
REQ-011 SHALL have port rdata  output  RF_WIDTH  registered read data.
REQ-012 SHALL have port rvalid  output  1  one-cycle pulse marking rdata valid.
REQ-013 SHALL have port ctrl  output  RF_WIDTH-1  CTRL[31:1] contents.
REQ-014 SHALL have port fifo_rst_n  output  1  active-low event-FIFO reset, registered.
REQ-015 SHALL have port fifo_rd_en  output  1  one-cycle event-FIFO pop.
REQ-016 SHALL have port fifo_rdata  input  RF_WIDTH  FIFO head word.
REQ-017 SHALL have port fifo_numel  input  10  FIFO occupancy (0..1023).

Function
REQ-018 SHALL decode: 0x0 CTRL (RW), 0x1 STATUS (RO + W1C), 0x2 FIFO_DATA (RO, pop-on-read), 0x3-0xF GP (RW storage).
REQ-019 SHALL perform a write on the clk edge where req=1 and we=1; only bytes with wmask[i]=1 change; wmask=0 is a no-op.
REQ-020 SHALL ignore writes to FIFO_DATA and to STATUS bits other than bit 16.
REQ-021 SHALL, on req=1 and we=0, load rdata and pulse rvalid on the following edge (latency 1); rdata holds until the next read.
REQ-022 SHALL keep rvalid=0 for writes and leave rdata unchanged.
REQ-023 SHALL return STATUS as {15'b0, underflow, 6'b0, fifo_numel}.
REQ-024 SHALL, on a FIFO_DATA read with fifo_numel!=0, return fifo_rdata sampled at req and assert fifo_rd_en for exactly that request's next cycle.
REQ-025 SHALL, on a FIFO_DATA read with fifo_numel=0, return 0, keep fifo_rd_en=0, and set sticky underflow.
REQ-026 SHALL clear underflow on a STATUS write with wmask[2]=1 and wdata[16]=1; a same-cycle set wins over clear.
REQ-027 SHALL treat CTRL bit 0 as self-clearing: a write with wmask[0]=1 and wdata[0]=1 drives fifo_rst_n=0 for exactly one cycle and clears underflow; CTRL bit 0 reads as 0.
REQ-028 SHALL export CTRL[31:1] on ctrl, updated the cycle after the write.
REQ-029 SHALL accept back-to-back req on consecutive cycles with no stall; each read yields its own rvalid pulse in order.
REQ-030 SHALL, on a read of a word written in the immediately preceding cycle, return the new value.

Reset
REQ-031 SHALL, while rst_n=0, force all registers, rdata, ctrl, underflow to 0, rvalid=0, fifo_rd_en=0, fifo_rst_n=0.
REQ-032 SHALL release fifo_rst_n to 1 on the first clk edge after rst_n deasserts.
REQ-033 SHALL abandon any read in flight on reset assertion; no rvalid is emitted for it afterwards.

Verification
REQ-034 Byte write: wmask=4'b1000, wdata=0x55000000 to 0x3 after reset, then read 0x3 -> rdata=0x55000000, rvalid one cycle after req.
REQ-035 Merge: write 0x6 with 0xAABB0000 mask 4'b1100, then 0x000011 22 mask 4'b0011 (0x00001122) -> read returns 0xAABB1122.
REQ-036 FIFO pop: fifo_numel=3, fifo_rdata=0xCCCCDDDD, read 0x2 -> rdata=0xCCCCDDDD, fifo_rd_en single pulse; STATUS read returns 0x00000003 (with numel held 3).
REQ-037 Underflow: fifo_numel=0, read 0x2 -> rdata=0, no fifo_rd_en; STATUS bit16=1; write 0x00010000 mask 4'b0100 to 0x1 -> bit16=0.
REQ-038 CTRL: write 0x0 with 0x80000003 -> fifo_rst_n low exactly one cycle, ctrl=0x40000001, read 0x0 returns 0x80000002.
REQ-039 Reset mid-read: assert rst_n=0 the cycle after a read req -> rvalid stays 0, rdata=0, fifo_rst_n=0 until first edge after release.

Source files
------------

// File: rtl/spi_regfile.sv
// Register file behind the SPI peripheral: CTRL, STATUS, event-FIFO window and GP storage,
// with byte-masked writes and single-cycle registered reads.
module spi_regfile #(
    parameter int RF_AWIDTH = 4,
    parameter int RF_WIDTH  = 32,
    parameter int RF_MASK   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [RF_AWIDTH-1:0] addr,
    input  logic [RF_WIDTH-1:0]  wdata,
    input  logic [RF_MASK-1:0]   wmask,
    output logic [RF_WIDTH-1:0]  rdata,
    output logic                 rvalid,
    output logic [RF_WIDTH-2:0]  ctrl,
    output logic                 fifo_rst_n,
    output logic                 fifo_rd_en,
    input  logic [RF_WIDTH-1:0]  fifo_rdata,
    input  logic [9:0]           fifo_numel
);
    localparam int DEPTH = 1 << RF_AWIDTH;
    localparam logic [RF_AWIDTH-1:0] ADDR_CTRL   = RF_AWIDTH'(0);
    localparam logic [RF_AWIDTH-1:0] ADDR_STATUS = RF_AWIDTH'(1);
    localparam logic [RF_AWIDTH-1:0] ADDR_FIFO   = RF_AWIDTH'(2);

    logic [RF_WIDTH-1:0] word_q [DEPTH];
    logic [RF_WIDTH-1:0] rdata_reg, rdata_next, status_word;
    logic                rvalid_reg, fifo_rd_en_reg, fifo_rst_n_reg, underflow_reg;
    logic                wr_req, rd_req, ctrl_pulse, uf_set, uf_clr;

    assign wr_req     = req & we;
    assign rd_req     = req & ~we;
    assign ctrl_pulse = wr_req & (addr == ADDR_CTRL) & wmask[0] & wdata[0];
    assign uf_set     = rd_req & (addr == ADDR_FIFO) & (fifo_numel == 10'd0);
    assign uf_clr     = ctrl_pulse | (wr_req & (addr == ADDR_STATUS) & wmask[2] & wdata[16]);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            if (gi == 1 || gi == 2) begin : g_none
                assign word_q[gi] = '0;
            end else begin : g_store
                // CTRL bit 0 is a command strobe, never stored.
                localparam logic [RF_WIDTH-1:0] KEEP =
                    (gi == 0) ? {{(RF_WIDTH-1){1'b1}}, 1'b0} : {RF_WIDTH{1'b1}};
                logic [RF_WIDTH-1:0] store_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        store_reg <= '0;
                    end else if (wr_req && addr == RF_AWIDTH'(gi)) begin
                        for (int b = 0; b < RF_MASK; b++) begin
                            if (wmask[b]) begin
                                store_reg[8*b +: 8] <= wdata[8*b +: 8] & KEEP[8*b +: 8];
                            end
                        end
                    end
                end
                assign word_q[gi] = store_reg;
            end
        end
    endgenerate

    always_comb begin
        status_word       = '0;
        status_word[16]   = underflow_reg;
        status_word[9:0]  = fifo_numel;
    end

    always_comb begin
        rdata_next = word_q[addr];
        case (addr)
            ADDR_STATUS: rdata_next = status_word;
            ADDR_FIFO:   rdata_next = (fifo_numel != 10'd0) ? fifo_rdata : '0;
            default:     rdata_next = word_q[addr];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg      <= '0;
            rvalid_reg     <= 1'b0;
            fifo_rd_en_reg <= 1'b0;
            fifo_rst_n_reg <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            rvalid_reg     <= rd_req;
            fifo_rd_en_reg <= rd_req & (addr == ADDR_FIFO) & (fifo_numel != 10'd0);
            fifo_rst_n_reg <= ~ctrl_pulse;
            if (rd_req) begin
                rdata_reg <= rdata_next;
            end
            // A pop on an empty FIFO in the same cycle as a clear keeps the flag set.
            if (uf_set) begin
                underflow_reg <= 1'b1;
            end else if (uf_clr) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign rdata      = rdata_reg;
    assign rvalid     = rvalid_reg;
    assign fifo_rd_en = fifo_rd_en_reg;
    assign fifo_rst_n = fifo_rst_n_reg;
    assign ctrl       = word_q[0][RF_WIDTH-1:1];
endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: inputs change and outputs are sampled on the falling edge.
module tb_spi_regfile;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic [30:0] ctrl;
    logic        fifo_rst_n;
    logic        fifo_rd_en;
    logic [31:0] fifo_rdata = '0;
    logic [9:0]  fifo_numel = '0;

    int checks = 0;
    int failures = 0;

    spi_regfile dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .wmask(wmask), .rdata(rdata), .rvalid(rvalid),
        .ctrl(ctrl), .fifo_rst_n(fifo_rst_n), .fifo_rd_en(fifo_rd_en),
        .fifo_rdata(fifo_rdata), .fifo_numel(fifo_numel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s got=%08h", tag, got);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; wmask = m;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        check("wr_no_rvalid", {31'd0, rvalid}, 32'd0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
        check(tag, rdata, exp);
        check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_rdata", rdata, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_ctrl", {1'b0, ctrl}, 32'd0);
        check("rst_fifo_rst_n", {31'd0, fifo_rst_n}, 32'd0);
        check("rst_fifo_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_fifo_rst_n_before_edge", {31'd0, fifo_rst_n}, 32'd0);
        @(negedge clk);
        check("rel_fifo_rst_n_after_edge", {31'd0, fifo_rst_n}, 32'd1);

        // Single-byte write
        wr(4'h3, 32'h55000000, 4'b1000);
        rd(4'h3, 32'h55000000, "byte_write");
        @(negedge clk);
        check("rvalid_single_pulse", {31'd0, rvalid}, 32'd0);

        // Byte-lane merge and mask=0 no-op
        wr(4'h6, 32'hAABB0000, 4'b1100);
        wr(4'h6, 32'h00001122, 4'b0011);
        rd(4'h6, 32'hAABB1122, "merge");
        wr(4'h6, 32'hFFFFFFFF, 4'b0000);
        rd(4'h6, 32'hAABB1122, "mask_zero_noop");

        // Writes to FIFO window are ignored and do not pop
        fifo_numel = 10'd3; fifo_rdata = 32'hCCCCDDDD;
        wr(4'h2, 32'h12345678, 4'b1111);
        check("fifo_wr_no_pop", {31'd0, fifo_rd_en}, 32'd0);

        // FIFO pop
        rd(4'h2, 32'hCCCCDDDD, "fifo_pop");
        check("fifo_rd_en_pulse", {31'd0, fifo_rd_en}, 32'd1);
        @(negedge clk);
        check("fifo_rd_en_single", {31'd0, fifo_rd_en}, 32'd0);
        rd(4'h1, 32'h00000003, "status_numel3");

        // Underflow set and W1C clear; other STATUS bits not writable
        fifo_numel = 10'd0;
        rd(4'h2, 32'h00000000, "underflow_read");
        check("underflow_no_pop", {31'd0, fifo_rd_en}, 32'd0);
        rd(4'h1, 32'h00010000, "status_uf_set");
        wr(4'h1, 32'h0000FFFF, 4'b0011);
        rd(4'h1, 32'h00010000, "status_ro_bits");
        wr(4'h1, 32'h00010000, 4'b0100);
        rd(4'h1, 32'h00000000, "status_uf_cleared");

        // CTRL self-clearing bit 0 also clears underflow
        rd(4'h2, 32'h00000000, "underflow_again");
        wr(4'h0, 32'h80000003, 4'b1111);
        check("ctrl_fifo_rst_low", {31'd0, fifo_rst_n}, 32'd0);
        check("ctrl_out", {1'b0, ctrl}, 32'h40000001);
        @(negedge clk);
        check("ctrl_fifo_rst_one_cycle", {31'd0, fifo_rst_n}, 32'd1);
        rd(4'h0, 32'h80000002, "ctrl_read");
        rd(4'h1, 32'h00000000, "ctrl_clears_uf");

        // Write then immediate read of the same word
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 4'h7; wdata = 32'h12345678; wmask = 4'b1111;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        req = 1'b0;
        check("raw_bypass", rdata, 32'h12345678);

        // Back-to-back reads
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 4'h3;
        @(negedge clk);
        addr = 4'h6;
        check("b2b_first", rdata, 32'h55000000);
        check("b2b_first_rvalid", {31'd0, rvalid}, 32'd1);
        @(negedge clk);
        req = 1'b0;
        check("b2b_second", rdata, 32'hAABB1122);
        check("b2b_second_rvalid", {31'd0, rvalid}, 32'd1);

        // Reset the cycle after a read request
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 4'h3;
        @(posedge clk);
        #1 req = 1'b0;
        rst_n = 1'b0;
        #1 check("midrd_rvalid", {31'd0, rvalid}, 32'd0);
        check("midrd_rdata", rdata, 32'd0);
        check("midrd_fifo_rst_n", {31'd0, fifo_rst_n}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("midrd_rvalid_held", {31'd0, rvalid}, 32'd0);
        rst_n = 1'b1;
        #1 check("midrd_fifo_rst_n_rel", {31'd0, fifo_rst_n}, 32'd0);
        @(negedge clk);
        check("midrd_rvalid_after", {31'd0, rvalid}, 32'd0);
        check("midrd_fifo_rst_n_up", {31'd0, fifo_rst_n}, 32'd1);
        check("midrd_ctrl_cleared", {1'b0, ctrl}, 32'd0);
        rd(4'h3, 32'h00000000, "gp_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
